mipi_tx_raw10_packer: RTL and testbench
=======================================

Name: mipi_tx_raw10_packer

Overview:
Transmit-side counterpart of the RAW10 depacker. Accepts 4 x 10-bit pixels per beat and packs them into the MIPI CSI-2 RAW10 byte stream: 5 bytes per 4 pixels. It emits that stream as 32-bit 4-lane words toward the CSI TX packet builder. It absorbs the 5:4 rate mismatch with an 8-byte residue buffer and valid/ready handshakes on both sides, and flushes a zero-padded partial word at line end.

Parameters:
PIX_W, 10, pixel width; fixed, checked at elaboration.
BUF_BYTES, 8, residue buffer depth in bytes; fixed.

Ports:
clk_i  input  1  pixel/byte clock
rst_n_i  input  1  asynchronous active-low reset
clear_i  input  1  synchronous drop of buffer contents and pending flush
pix_valid_i  input  1  pixel group valid
pix_ready_o  output  1  group accepted when pix_valid_i && pix_ready_o
pix_i  input  40  {p0[39:30], p1[29:20], p2[19:10], p3[9:0]}
line_end_i  input  1  qualifies the last pixel group of a line
valid_o  output  1  output word valid
ready_i  input  1  downstream ready
data_o  output  32  bytes; byte0 (first on wire) in [7:0], lane 1
keep_o  output  4  byte enables; bit n set = byte n valid
last_o  output  1  final word of the line

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous, active-low on rst_n_i.
- Packing per accepted group:
  - B0=p0[9:2], B1=p1[9:2], B2=p2[9:2], B3=p3[9:2].
  - B4={p0[1:0],p1[1:0],p2[1:0],p3[1:0]}, with p0 in bits 7:6.
- State: 64-bit byte buffer, cnt (0..8 bytes held), flush_pend.
- Output side:
  - valid_o = (cnt>=4) || (flush_pend && cnt!=0).
  - data_o = buffer bytes 0..3. Unheld bytes are driven 0.
  - keep_o = 4'hF when cnt>=4, else (1<<cnt)-1.
  - last_o = flush_pend && cnt<=4 && valid_o.
- out_fire = valid_o && ready_i. It removes min(cnt,4) bytes and shifts the remaining bytes down to byte 0.
- Input side:
  - pix_ready_o = !flush_pend && ((cnt - (out_fire ? 4 : 0)) <= 3).
  - This is a combinational path from ready_i to pix_ready_o (documented; the upstream must not loop it back).
  - in_fire appends B0..B4 after the bytes surviving the output shift, in the same cycle.
- Steady state with ready_i=1: cnt runs 0→5→6→7→8→4→5…
  - 5 words out per 4 groups in; no bubbles on the output.
  - pix_ready_o pattern is 1,1,1,1,0 repeating.
- Line end:
  - in_fire with line_end_i sets flush_pend.
  - No input is accepted while flush_pend=1.
  - The word with last_o=1 is padded with zeros in unused bytes.
  - Its out_fire clears flush_pend, and cnt becomes 0.
  - A line of 4N pixels yields ceil(5N/4) words.
- Line starting empty: line_end_i on a group accepted at cnt=0 gives 5 bytes, i.e. one full word then a keep=4'h1 last word.
- Backpressure: valid_o=1 with ready_i=0 holds data_o, keep_o and last_o stable (AXI-style). pix_ready_o recomputes from cnt only.
- clear_i:
  - Highest priority. Next cycle: cnt=0, flush_pend=0, buffer=0.
  - In-flight in_fire and out_fire in that cycle are discarded.
- Reset values (and mid-operation reset, immediate):
  - valid_o=0, data_o=0, keep_o=0, last_o=0.
  - cnt=0, flush_pend=0.
  - pix_ready_o=1 once rst_n_i is high.
- Latency: a byte accepted at edge k is visible on data_o after edge k (one register stage).

Decomposition:
- Shared package mipi_raw_pkg, common with the depacker:
  - RAW10_BYTES_PER_GROUP=5, RAW10_PIX_PER_GROUP=4, PIX_W=10, LANES=4.
  - Function raw10_pack(40b)→40b byte vector.
- No sub-module. Buffer, shift and append stay in one always block plus a small combinational pack function.

Test Plan:
- Single group p0=0x3FF, p1=0x000, p2=0x2AA, p3=0x155 with line_end_i, ready_i=1 → word 0x55AA00FF keep F last 0, then 0x000000C9 keep 1 last 1; pix_ready_o=0 until the last word fires.
- 16-pixel line (4 groups, incrementing pixels 0..15), ready_i=1 → exactly 5 words, last word keep F last 1, no output gaps. Repacking through the depacker returns the original pixels.
- Continuous 1024-group stream with ready_i=1 → pix_ready_o pattern 1,1,1,1,0 repeating; 1280 words out; cnt never exceeds 8.
- Random ready_i (50%) and pix_valid_i (70%) over 8-pixel lines → scoreboard byte stream matches the reference packing; data_o, keep_o and last_o stable while stalled; no drops or duplicates.
- clear_i asserted with cnt=6 and valid_o=1 → next cycle valid_o=0, cnt=0, pix_ready_o=1; the next group's B0 appears at data_o[7:0].
- rst_n_i pulsed low mid-line (asynchronously, between edges) → outputs go 0 immediately; after release the first group packs from byte 0.

Source files
------------

// File: rtl/mipi_raw_pkg.sv
// rtl/mipi_raw_pkg.sv - RAW10 constants and pixel-to-byte packing shared by packer and depacker
package mipi_raw_pkg;

  localparam int RAW10_BYTES_PER_GROUP = 5;
  localparam int RAW10_PIX_PER_GROUP   = 4;
  localparam int PIX_W                 = 10;
  localparam int LANES                 = 4;

  // pix = {p0,p1,p2,p3}; result byte n sits in [8n+7:8n], byte 4 carries the LSB pairs
  function automatic logic [39:0] raw10_pack(input logic [39:0] pix);
    logic [39:0] b;
    b[7:0]   = pix[39:32];
    b[15:8]  = pix[29:22];
    b[23:16] = pix[19:12];
    b[31:24] = pix[9:2];
    b[39:32] = {pix[31:30], pix[21:20], pix[11:10], pix[1:0]};
    return b;
  endfunction

endpackage

// File: rtl/mipi_tx_raw10_packer.sv
// rtl/mipi_tx_raw10_packer.sv - packs 4x10-bit pixel groups into a 32-bit CSI-2 RAW10 byte stream
module mipi_tx_raw10_packer
  import mipi_raw_pkg::*;
#(
  parameter int PIX_W     = 10,
  parameter int BUF_BYTES = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 clear_i,
  input  logic                 pix_valid_i,
  output logic                 pix_ready_o,
  input  logic [4*PIX_W-1:0]   pix_i,
  input  logic                 line_end_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [31:0]          data_o,
  output logic [3:0]           keep_o,
  output logic                 last_o
);

  if (PIX_W != mipi_raw_pkg::PIX_W || BUF_BYTES != 8) begin : g_param_chk
    $error("mipi_tx_raw10_packer supports only PIX_W=10 and BUF_BYTES=8");
  end

  logic [8*BUF_BYTES-1:0] buf_q, buf_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   flush_q, flush_d;

  logic       out_fire, in_fire;
  logic [3:0] rm_bytes, surv;
  logic [63:0] pack64;

  // Bytes at or above cnt_q are always zero, so data_o needs no masking
  assign valid_o     = (cnt_q >= 4'd4) || (flush_q && (cnt_q != 4'd0));
  assign data_o      = buf_q[31:0];
  assign keep_o      = (cnt_q >= 4'd4) ? 4'hF : ~(4'hF << cnt_q[1:0]);
  assign last_o      = flush_q && (cnt_q <= 4'd4) && valid_o;

  assign out_fire    = valid_o && ready_i;
  assign rm_bytes    = out_fire ? ((cnt_q >= 4'd4) ? 4'd4 : cnt_q) : 4'd0;
  assign surv        = cnt_q - rm_bytes;

  // Combinational from ready_i: a word leaving this cycle frees room for the next group
  assign pix_ready_o = !flush_q && (surv <= 4'd3);
  assign in_fire     = pix_valid_i && pix_ready_o;
  assign pack64      = {24'd0, raw10_pack(pix_i)};

  always_comb begin
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    flush_d = flush_q;
    if (clear_i) begin
      buf_d   = '0;
      cnt_d   = 4'd0;
      flush_d = 1'b0;
    end else begin
      buf_d = buf_q >> {rm_bytes, 3'b000};
      cnt_d = surv;
      if (in_fire) begin
        buf_d = buf_d | (pack64 << {surv, 3'b000});
        cnt_d = surv + 4'd5;
        if (line_end_i) flush_d = 1'b1;
      end else if (out_fire && last_o) begin
        flush_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      buf_q   <= '0;
      cnt_q   <= 4'd0;
      flush_q <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

endmodule

// File: tb/tb_mipi_tx_raw10_packer.sv
// tb/tb_mipi_tx_raw10_packer.sv - directed and scoreboarded bench for the RAW10 transmit packer
module tb_mipi_tx_raw10_packer;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        pix_valid_i = 1'b0;
  logic        pix_ready_o;
  logic [39:0] pix_i = '0;
  logic        line_end_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [31:0] data_o;
  logic [3:0]  keep_o;
  logic        last_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic        rand_rdy = 1'b0;
  logic        rdy_fix = 1'b1;
  logic        stall_chk = 1'b0;
  logic        stall_q = 1'b0;
  logic [36:0] stall_w = '0;
  logic        pat_en = 1'b0;
  int          pat_i = 0;
  int          pat_bad = 0;

  logic [36:0] got[$];
  int          got_cyc[$];
  logic [36:0] exp_w[$];
  logic [7:0]  exp_b[$];

  mipi_tx_raw10_packer dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .clear_i(clear_i),
    .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o), .pix_i(pix_i),
    .line_end_i(line_end_i), .valid_o(valid_o), .ready_i(ready_i),
    .data_o(data_o), .keep_o(keep_o), .last_o(last_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  always @(posedge clk_i) begin
    #1;
    ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fix;
  end

  task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got_v, exp_v);
    end
  endtask

  always @(negedge clk_i) begin
    if (valid_o && ready_i) begin
      got.push_back({last_o, keep_o, data_o});
      got_cyc.push_back(cyc);
    end
    if (stall_chk) begin
      if (stall_q) begin
        check("stall_valid", 64'(valid_o), 64'd1);
        check("stall_word", 64'({last_o, keep_o, data_o}), 64'(stall_w));
      end
      stall_q = valid_o && !ready_i;
      stall_w = {last_o, keep_o, data_o};
    end else begin
      stall_q = 1'b0;
    end
    if (pat_en && pix_valid_i) begin
      if (pix_ready_o != ((pat_i % 5) != 4)) pat_bad++;
      pat_i++;
    end
  end

  function automatic logic [39:0] ref_pack(input logic [39:0] p);
    logic [39:0] b;
    logic [9:0]  px;
    b = '0;
    for (int k = 0; k < 4; k++) begin
      px = p[39-10*k -: 10];
      b[8*k +: 8] = px[9:2];
      b[39-2*k -: 2] = px[1:0];
    end
    return b;
  endfunction

  task automatic exp_group(input logic [39:0] p, input logic le);
    logic [39:0] v;
    logic [31:0] w;
    logic [3:0]  kp;
    int n;
    v = ref_pack(p);
    for (int i = 0; i < 5; i++) exp_b.push_back(v[8*i +: 8]);
    while (exp_b.size() > 4 || (exp_b.size() == 4 && !le)) begin
      w = '0;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = exp_b.pop_front();
      exp_w.push_back({1'b0, 4'hF, w});
    end
    if (le) begin
      w = '0;
      kp = '0;
      n = exp_b.size();
      for (int i = 0; i < n; i++) begin
        w[8*i +: 8] = exp_b.pop_front();
        kp[i] = 1'b1;
      end
      exp_w.push_back({1'b1, kp, w});
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the group was accepted
  task automatic send_group(input logic [39:0] p, input logic le);
    logic ok;
    int n;
    ok = 1'b0;
    n = 0;
    pix_valid_i = 1'b1;
    pix_i = p;
    line_end_i = le;
    while (!ok && n < 200) begin
      @(negedge clk_i);
      ok = pix_ready_o;
      n++;
      @(posedge clk_i);
      #1;
    end
    pix_valid_i = 1'b0;
    line_end_i = 1'b0;
    if (!ok) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_words(input string tag, input int n, input int budget);
    int c;
    c = 0;
    while (got.size() < n && c < budget) begin
      @(posedge clk_i);
      #1;
      c++;
    end
    check(tag, 64'(got.size()), 64'(n));
  endtask

  task automatic compare_stream(input string tag);
    int n;
    check({tag, "_count"}, 64'(got.size()), 64'(exp_w.size()));
    n = (got.size() < exp_w.size()) ? got.size() : exp_w.size();
    for (int i = 0; i < n; i++) check(tag, 64'(got[i]), 64'(exp_w[i]));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bb [20];
    logic [9:0] px;
    int bad;

    #12;
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_data", 64'(data_o), 64'd0);
    check("rst_keep", 64'(keep_o), 64'd0);
    check("rst_last", 64'(last_o), 64'd0);
    @(posedge clk_i);
    #3 rst_n_i = 1'b1;
    @(negedge clk_i);
    check("rst_pix_ready", 64'(pix_ready_o), 64'd1);
    @(posedge clk_i);
    #1;

    // Single group with line end
    send_group({10'h3FF, 10'h000, 10'h2AA, 10'h155}, 1'b1);
    @(negedge clk_i);
    check("t1_w0", 64'({last_o, keep_o, data_o, valid_o}), 64'({1'b0, 4'hF, 32'h55AA00FF, 1'b1}));
    check("t1_rdy0", 64'(pix_ready_o), 64'd0);
    @(negedge clk_i);
    check("t1_w1", 64'({last_o, keep_o, data_o, valid_o}), 64'({1'b1, 4'h1, 32'h000000C9, 1'b1}));
    check("t1_rdy1", 64'(pix_ready_o), 64'd0);
    @(negedge clk_i);
    check("t1_idle_valid", 64'(valid_o), 64'd0);
    check("t1_idle_rdy", 64'(pix_ready_o), 64'd1);
    @(posedge clk_i);
    #1;

    // 16-pixel line, incrementing pixels
    got.delete();
    got_cyc.delete();
    for (int g = 0; g < 4; g++)
      send_group({10'(4*g), 10'(4*g+1), 10'(4*g+2), 10'(4*g+3)}, g == 3);
    wait_words("t2_words", 5, 50);
    if (got.size() >= 5) begin
      check("t2_w0", 64'(got[0]), 64'({1'b0, 4'hF, 32'h00000000}));
      check("t2_w1", 64'(got[1]), 64'({1'b0, 4'hF, 32'h0101011B}));
      check("t2_w2", 64'(got[2]), 64'({1'b0, 4'hF, 32'h02021B01}));
      check("t2_w3", 64'(got[3]), 64'({1'b0, 4'hF, 32'h031B0202}));
      check("t2_w4", 64'(got[4]), 64'({1'b1, 4'hF, 32'h1B030303}));
      check("t2_gap", 64'(got_cyc[4] - got_cyc[0]), 64'd4);
      for (int w = 0; w < 5; w++)
        for (int j = 0; j < 4; j++) bb[4*w+j] = got[w][8*j +: 8];
      bad = 0;
      for (int g = 0; g < 4; g++)
        for (int k = 0; k < 4; k++) begin
          px = {bb[5*g+k], bb[5*g+4][7-2*k -: 2]};
          if (px != 10'(4*g+k)) bad++;
        end
      check("t2_depack", 64'(bad), 64'd0);
    end
    idle(3);

    // Continuous 1024-group stream
    got.delete();
    got_cyc.delete();
    exp_w.delete();
    exp_b.delete();
    pat_i = 0;
    pat_bad = 0;
    pat_en = 1'b1;
    for (int g = 0; g < 1024; g++) begin
      logic [39:0] p;
      p = {10'(4*g), 10'(4*g+1), 10'(4*g+2), 10'(4*g+3)};
      exp_group(p, g == 1023);
      send_group(p, g == 1023);
    end
    pat_en = 1'b0;
    wait_words("t3_words", 1280, 200);
    check("t3_rdy_pattern", 64'(pat_bad), 64'd0);
    check("t3_pattern_len", 64'(pat_i > 1200), 64'd1);
    compare_stream("t3_word");
    if (got.size() == 1280) check("t3_gap", 64'(got_cyc[1279] - got_cyc[0]), 64'd1279);
    idle(3);

    // Random valid/ready, 8-pixel lines
    got.delete();
    got_cyc.delete();
    exp_w.delete();
    exp_b.delete();
    rand_rdy = 1'b1;
    stall_chk = 1'b1;
    for (int l = 0; l < 40; l++)
      for (int g = 0; g < 2; g++) begin
        logic [39:0] p;
        if ($urandom_range(0, 9) < 3) idle(1);
        p = {8'($urandom()), 32'($urandom())};
        exp_group(p, g == 1);
        send_group(p, g == 1);
      end
    wait_words("t4_words", 120, 3000);
    stall_chk = 1'b0;
    rand_rdy = 1'b0;
    compare_stream("t4_word");
    idle(3);

    // clear_i with cnt=6 and a word pending
    send_group({10'h011, 10'h022, 10'h033, 10'h044}, 1'b0);
    send_group({10'h055, 10'h066, 10'h077, 10'h088}, 1'b0);
    clear_i = 1'b1;
    @(negedge clk_i);
    check("t5_pre_valid", 64'({valid_o, keep_o}), 64'({1'b1, 4'hF}));
    @(posedge clk_i);
    #1 clear_i = 1'b0;
    @(negedge clk_i);
    check("t5_valid", 64'(valid_o), 64'd0);
    check("t5_keep_data", 64'({keep_o, data_o}), 64'd0);
    check("t5_rdy", 64'(pix_ready_o), 64'd1);
    @(posedge clk_i);
    #1;
    send_group({10'h123, 10'h045, 10'h3C0, 10'h0FF}, 1'b1);
    @(negedge clk_i);
    check("t5_b0", 64'(data_o[7:0]), 64'h48);
    idle(4);

    // Asynchronous reset mid-line
    rdy_fix = 1'b0;
    idle(1);
    send_group({10'h155, 10'h2AA, 10'h0F0, 10'h30F}, 1'b0);
    @(negedge clk_i);
    check("t6_pre_valid", 64'(valid_o), 64'd1);
    #2 rst_n_i = 1'b0;
    #1;
    check("t6_valid", 64'(valid_o), 64'd0);
    check("t6_data", 64'(data_o), 64'd0);
    check("t6_keep_last", 64'({keep_o, last_o}), 64'd0);
    #3 rst_n_i = 1'b1;
    rdy_fix = 1'b1;
    idle(2);
    send_group({10'h200, 10'h104, 10'h08C, 10'h3FC}, 1'b1);
    @(negedge clk_i);
    check("t6_first_word", 64'({last_o, keep_o, data_o}), 64'({1'b0, 4'hF, 32'hFF234180}));
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
